// File: rtl/host_packet_assembler.sv
// Hunts framed packets (SYNC, TYPE, LEN, payload, CSUM) in a UART byte stream,
// verifies the XOR checksum and emits each good frame as 64-bit AXI-Stream beats.
module host_packet_assembler #(
  parameter int          MAX_PAYLOAD = 24,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_s_axis_tdata,
  input  logic        i_s_axis_tvalid,
  output logic        o_s_axis_tready,
  output logic [63:0] o_m_axis_tdata,
  output logic        o_m_axis_tvalid,
  output logic        o_m_axis_tlast,
  input  logic        i_m_axis_tready,
  output logic        o_frame_err,
  output logic [7:0]  o_err_count
);

  // Buffer is padded to a whole number of 6-byte beats so lane lookups stay in range.
  localparam int         BUF_DEPTH   = ((MAX_PAYLOAD + 5) / 6) * 6;
  localparam int         BUF_AW      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [7:0] MAX_LEN     = 8'(MAX_PAYLOAD);
  localparam logic [7:0] BUF_DEPTH_B = 8'(BUF_DEPTH);

  localparam logic [2:0] ST_HUNT    = 3'd0;
  localparam logic [2:0] ST_TYPE    = 3'd1;
  localparam logic [2:0] ST_LEN     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_CSUM    = 3'd4;
  localparam logic [2:0] ST_SEND    = 3'd5;

  logic [2:0]  r_state;
  logic [7:0]  r_type;
  logic [7:0]  r_len;
  logic [7:0]  r_xor;
  logic [7:0]  r_cnt;
  logic [7:0]  r_beat;
  logic [63:0] r_tdata;
  logic        r_tvalid;
  logic        r_tlast;
  logic        r_frame_err;
  logic [7:0]  r_err_count;
  logic [7:0]  r_buf [BUF_DEPTH];

  logic        w_take;
  logic [7:0]  w_sel_beat;
  logic [7:0]  w_last_beat;
  logic [63:0] w_beat_data;
  logic        w_beat_last;
  logic [7:0]  w_err_inc;

  assign o_s_axis_tready = (r_state != ST_SEND);
  assign w_take          = i_s_axis_tvalid && o_s_axis_tready;

  // Beat being built: beat 0 while checking CSUM, otherwise the one after the current beat.
  assign w_sel_beat  = (r_state == ST_CSUM) ? 8'd0 : r_beat + 8'd1;
  assign w_last_beat = (r_len == 8'd0) ? 8'd0 : (r_len - 8'd1) / 8'd6;
  assign w_beat_last = (w_sel_beat == w_last_beat);

  assign w_beat_data[7:0]  = r_type;
  assign w_beat_data[15:8] = w_sel_beat;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_lane
      logic [7:0] w_pos;
      assign w_pos = w_sel_beat * 8'd6 + 8'(gi);
      assign w_beat_data[8*(gi+2) +: 8] =
        ((w_pos < r_len) && (w_pos < BUF_DEPTH_B)) ? r_buf[w_pos[BUF_AW-1:0]] : 8'd0;
    end
  endgenerate

  assign w_err_inc = (r_err_count == 8'hFF) ? 8'hFF : r_err_count + 8'd1;

  // Payload storage carries no reset; stale bytes are masked by the length compare.
  always_ff @(posedge i_clk) begin
    if (w_take && (r_state == ST_PAYLOAD)) begin
      r_buf[r_cnt[BUF_AW-1:0]] <= i_s_axis_tdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_HUNT;
      r_type      <= 8'd0;
      r_len       <= 8'd0;
      r_xor       <= 8'd0;
      r_cnt       <= 8'd0;
      r_beat      <= 8'd0;
      r_tdata     <= 64'd0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        ST_HUNT: begin
          if (w_take && (i_s_axis_tdata == SYNC_BYTE)) r_state <= ST_TYPE;
        end
        ST_TYPE: begin
          if (w_take) begin
            r_type  <= i_s_axis_tdata;
            r_xor   <= i_s_axis_tdata;
            r_state <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (w_take) begin
            r_len <= i_s_axis_tdata;
            r_xor <= r_xor ^ i_s_axis_tdata;
            r_cnt <= 8'd0;
            if (i_s_axis_tdata > MAX_LEN) begin
              r_frame_err <= 1'b1;
              r_err_count <= w_err_inc;
              r_state     <= ST_HUNT;
            end else if (i_s_axis_tdata == 8'd0) begin
              r_state <= ST_CSUM;
            end else begin
              r_state <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (w_take) begin
            r_xor <= r_xor ^ i_s_axis_tdata;
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt + 8'd1 == r_len) r_state <= ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (w_take) begin
            if (i_s_axis_tdata == r_xor) begin
              r_tdata  <= w_beat_data;
              r_tlast  <= w_beat_last;
              r_tvalid <= 1'b1;
              r_beat   <= 8'd0;
              r_state  <= ST_SEND;
            end else begin
              r_frame_err <= 1'b1;
              r_err_count <= w_err_inc;
              r_state     <= ST_HUNT;
            end
          end
        end
        ST_SEND: begin
          if (r_tvalid && i_m_axis_tready) begin
            if (r_tlast) begin
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_state  <= ST_HUNT;
            end else begin
              r_tdata <= w_beat_data;
              r_tlast <= w_beat_last;
              r_beat  <= r_beat + 8'd1;
            end
          end
        end
        default: r_state <= ST_HUNT;
      endcase
    end
  end

  assign o_m_axis_tdata  = r_tdata;
  assign o_m_axis_tvalid = r_tvalid;
  assign o_m_axis_tlast  = r_tlast;
  assign o_frame_err     = r_frame_err;
  assign o_err_count     = r_err_count;

endmodule

// File: tb/tb_host_packet_assembler.sv
// Scoreboard bench: expected beats are queued as frames are driven and
// compared as the assembler hands them to the (sometimes stalled) sink.
module tb_host_packet_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
  logic        frame_err;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  host_packet_assembler #(.MAX_PAYLOAD(24), .SYNC_BYTE(8'hA5)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_s_axis_tdata  (s_tdata),
    .i_s_axis_tvalid (s_tvalid),
    .o_s_axis_tready (s_tready),
    .o_m_axis_tdata  (m_tdata),
    .o_m_axis_tvalid (m_tvalid),
    .o_m_axis_tlast  (m_tlast),
    .i_m_axis_tready (m_tready),
    .o_frame_err     (frame_err),
    .o_err_count     (err_count)
  );

  logic [64:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;
  int err_pulses = 0;

  task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Sink monitor: scoreboard compare, AXIS hold rule, frame_err pulse counter.
  logic        prev_stall = 1'b0;
  logic [64:0] prev_beat  = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_err) err_pulses++;
      if (prev_stall) check_val("hold", {5'd0, m_tvalid, m_tlast, m_tdata}, {5'd0, 1'b1, prev_beat});
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check_val("sb_depth", 72'(exp_q.size()), 72'd1);
        end else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          $display("beat tdata=%h tlast=%0d", m_tdata, m_tlast);
          check_val("beat", {7'd0, m_tlast, m_tdata}, {7'd0, e});
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tlast, m_tdata};
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    while (!s_tready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (!s_tready) check_val("in_timeout", 72'(s_tready), 72'd1);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_raw(input logic [7:0] bytes [$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic push_model(input logic [7:0] typ, input logic [7:0] pl [$]);
    int len = pl.size();
    int nb = (len == 0) ? 1 : (len + 5) / 6;
    for (int k = 0; k < nb; k++) begin
      logic [63:0] d = '0;
      d[7:0]  = typ;
      d[15:8] = 8'(k);
      for (int j = 0; j < 6; j++)
        if (6 * k + j < len) d[8*(j+2) +: 8] = pl[6*k+j];
      exp_q.push_back({(k == nb - 1), d});
    end
  endtask

  task automatic send_frame(input logic [7:0] typ, input logic [7:0] pl [$]);
    logic [7:0] cs = typ ^ 8'(pl.size());
    send_byte(8'hA5);
    send_byte(typ);
    send_byte(8'(pl.size()));
    foreach (pl[i]) begin
      send_byte(pl[i]);
      cs ^= pl[i];
    end
    push_model(typ, pl);
    send_byte(cs);
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check_val(tag, 72'(exp_q.size()), 72'd0);
    @(posedge clk); #1;
    check_val({tag, "_idle"}, {70'd0, m_tvalid, s_tready}, 72'd1);
  endtask

  initial begin
    logic [7:0] pl [$];
    int e0;
    rst_n = 1'b0; s_tdata = 8'd0; s_tvalid = 1'b0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out", {m_tvalid, m_tlast, frame_err, s_tready, err_count, m_tdata},
              {1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 64'd0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-beat frame, first beat one cycle after CSUM.
    send_raw('{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20});
    exp_q.push_back({1'b1, 64'h0000_0000_2010_0001});
    send_byte(8'h33);
    check_val("t1_latency", {71'd0, m_tvalid}, 72'd1);
    wait_drain("t1_drain");

    // Multi-beat frame with sink stalled on beat 0.
    m_tready = 1'b0;
    send_raw('{8'hA5, 8'h03, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07});
    exp_q.push_back({1'b0, 64'h0504_0302_0100_0003});
    exp_q.push_back({1'b1, 64'h0000_0000_0706_0103});
    send_byte(8'h0B);
    for (int i = 0; i < 3; i++) begin
      check_val("t2_stall", {s_tready, m_tvalid, m_tlast, 5'd0, m_tdata},
                {1'b0, 1'b1, 1'b0, 5'd0, 64'h0504_0302_0100_0003});
      @(posedge clk); #1;
    end
    m_tready = 1'b1;
    wait_drain("t2_drain");

    // Bad checksum, then a good frame.
    e0 = err_pulses;
    send_raw('{8'hA5, 8'h01, 8'h01, 8'h55, 8'h00});
    repeat (2) @(posedge clk);
    #1;
    check_val("t3_pulses", 72'(err_pulses - e0), 72'd1);
    check_val("t3_count", {64'd0, err_count}, 72'd1);
    check_val("t3_nobeat", {71'd0, m_tvalid}, 72'd0);
    send_frame(8'h04, '{8'hDE, 8'hAD});
    wait_drain("t3_drain");

    // Oversize length, trailing garbage, then zero-length frame.
    e0 = err_pulses;
    send_raw('{8'hA5, 8'h01, 8'h19, 8'h00, 8'h01, 8'h02, 8'h03});
    check_val("t4_pulses", 72'(err_pulses - e0), 72'd1);
    check_val("t4_count", {64'd0, err_count}, 72'd2);
    send_raw('{8'hA5, 8'h02, 8'h00});
    exp_q.push_back({1'b1, 64'h0000_0000_0000_0002});
    send_byte(8'h02);
    wait_drain("t4_drain");

    // Garbage before sync.
    send_raw('{8'h11, 8'h22, 8'hA5, 8'h01, 8'h00});
    exp_q.push_back({1'b1, 64'h0000_0000_0000_0001});
    send_byte(8'h01);
    wait_drain("t5_drain");

    // Max-length frame carrying SYNC as data, random sink backpressure.
    pl = {};
    for (int i = 0; i < 24; i++) pl.push_back(8'($urandom_range(0, 255)));
    pl[3] = 8'hA5;
    send_frame(8'h07, pl);
    for (int i = 0; i < 40; i++) begin
      m_tready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    m_tready = 1'b1;
    wait_drain("t6_drain");

    // Asynchronous reset mid-payload.
    send_raw('{8'hA5, 8'h05, 8'h04, 8'h11, 8'h22});
    #2 rst_n = 1'b0;
    #1;
    check_val("t7_rst", {m_tvalid, m_tlast, frame_err, s_tready, err_count, m_tdata},
              {1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 64'd0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_frame(8'h06, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07});
    wait_drain("t7_drain");

    // Error counter saturation.
    for (int i = 0; i < 260; i++) send_raw('{8'hA5, 8'h01, 8'hFF});
    @(posedge clk); #1;
    check_val("t8_sat", {64'd0, err_count}, 72'd255);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
